// File: rtl/tile_render_engine.sv
`default_nettype none
// tile_render_engine: one 2048 tile with state palette, centred 2^state digits and a pop border.
// A double-dabble FSM produces the digits; results commit at frame_start only while idle.

module font_rom #(
   parameter int FONT_W = 16,
   parameter int FONT_H = 32
) (
   input  logic [3:0]        code,
   input  logic [11:0]       row,
   output logic [FONT_W-1:0] output_row
);
   localparam int M = 2;
   localparam int T = (FONT_W / 8 > 0) ? FONT_W / 8 : 1;

   logic [6:0] seg;
   int         r;
   logic       ra, rg, rd, ru, rl, hl, lc, rc;

   // Seven-segment glyphs scaled to the font box; segment order is a..g from bit 6 down.
   always_comb begin
      case (code)
         4'd0:    seg = 7'h7E;
         4'd1:    seg = 7'h30;
         4'd2:    seg = 7'h6D;
         4'd3:    seg = 7'h79;
         4'd4:    seg = 7'h33;
         4'd5:    seg = 7'h5B;
         4'd6:    seg = 7'h5F;
         4'd7:    seg = 7'h70;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h7B;
         default: seg = 7'h00;
      endcase
      r  = int'(row);
      ra = (r >= M) && (r < M + T);
      rg = (r >= FONT_H / 2 - 1) && (r < FONT_H / 2 + 1);
      rd = (r >= FONT_H - M - T) && (r < FONT_H - M);
      ru = (r >= M) && (r < FONT_H / 2 + 1);
      rl = (r >= FONT_H / 2 - 1) && (r < FONT_H - M);
      hl = 1'b0;
      lc = 1'b0;
      rc = 1'b0;
      output_row = '0;
      for (int c = 0; c < FONT_W; c++) begin
         hl = (c >= M) && (c < FONT_W - M);
         lc = (c >= M) && (c < M + T);
         rc = (c >= FONT_W - M - T) && (c < FONT_W - M);
         output_row[FONT_W-1-c] = (seg[6] & ra & hl) | (seg[5] & ru & rc) | (seg[4] & rl & rc) |
                                  (seg[3] & rd & hl) | (seg[2] & rl & lc) | (seg[1] & ru & lc) |
                                  (seg[0] & rg & hl);
      end
   end
endmodule

module tile_render_engine #(
   parameter int X0          = 0,
   parameter int Y0          = 0,
   parameter int TILE_SIZE   = 148,
   parameter int FONT_W      = 16,
   parameter int FONT_H      = 32,
   parameter int ANIM_FRAMES = 8,
   parameter int BORDER_W    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  state,
   input  logic [11:0] h_cnt,
   input  logic [11:0] v_cnt,
   input  logic        frame_start,
   output logic [11:0] vga_data,
   output logic        in_tile,
   output logic        busy
);
   localparam int CW = (FONT_W > 1) ? $clog2(FONT_W) : 1;
   localparam int GY = Y0 + (TILE_SIZE - FONT_H) / 2;
   localparam logic [FONT_W-1:0] COL0_MASK = {1'b1, {(FONT_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} fsm_t;

   fsm_t        fsm;
   logic [3:0]  conv_state, shadow_state, com_state, sh_cnt;
   logic [13:0] bin;
   logic [15:0] bcd, bcd_adj, shadow_bcd, com_bcd;
   logic [2:0]  shadow_ndig, com_ndig, done_ndig;
   logic [7:0]  anim_cnt;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      if (conv_state == 4'd0)        done_ndig = 3'd0;
      else if (bcd[15:12] != 4'd0)   done_ndig = 3'd4;
      else if (bcd[11:8] != 4'd0)    done_ndig = 3'd3;
      else if (bcd[7:4] != 4'd0)     done_ndig = 3'd2;
      else                           done_ndig = 3'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm          <= IDLE;
         busy         <= 1'b0;
         conv_state   <= 4'd0;
         shadow_state <= 4'd0;
         sh_cnt       <= 4'd0;
         bin          <= '0;
         bcd          <= '0;
         shadow_bcd   <= '0;
         shadow_ndig  <= 3'd0;
      end else begin
         case (fsm)
            IDLE: begin
               if (state != shadow_state) begin
                  fsm  <= LOAD;
                  busy <= 1'b1;
               end
            end
            LOAD: begin
               bin        <= (state == 4'd0) ? 14'd0 : (14'd1 << state);
               bcd        <= '0;
               sh_cnt     <= 4'd0;
               conv_state <= state;
               fsm        <= SHIFT;
            end
            SHIFT: begin
               if (state != conv_state) begin
                  fsm <= LOAD;
               end else begin
                  {bcd, bin} <= {bcd_adj, bin} << 1;
                  sh_cnt     <= sh_cnt + 4'd1;
                  if (sh_cnt == 4'd13) fsm <= DONE;
               end
            end
            DONE: begin
               shadow_bcd   <= bcd;
               shadow_ndig  <= done_ndig;
               shadow_state <= conv_state;
               fsm          <= IDLE;
               busy         <= 1'b0;
            end
            default: begin
               fsm  <= IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end

   // Commit happens only at frame boundaries so a frame never mixes two values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         com_state <= 4'd0;
         com_bcd   <= '0;
         com_ndig  <= 3'd0;
         anim_cnt  <= 8'd0;
      end else if (frame_start) begin
         if (fsm == IDLE) begin
            com_state <= shadow_state;
            com_bcd   <= shadow_bcd;
            com_ndig  <= shadow_ndig;
         end
         if (fsm == IDLE && shadow_state > com_state && shadow_state != 4'd0)
            anim_cnt <= 8'(ANIM_FRAMES);
         else if (anim_cnt != 8'd0)
            anim_cnt <= anim_cnt - 8'd1;
      end
   end

   int          h, v, txt_w, dx, dy, slot, digit_idx;
   logic [11:0] gx;
   logic        tile_hit, border_hit, glyph_hit;
   logic [3:0]  code;

   always_comb begin
      h          = int'(h_cnt);
      v          = int'(v_cnt);
      txt_w      = int'(com_ndig) * FONT_W;
      gx         = 12'(X0 + (TILE_SIZE - txt_w) / 2);
      dx         = h - int'(gx);
      dy         = v - GY;
      tile_hit   = (h >= X0) && (h < X0 + TILE_SIZE) && (v >= Y0) && (v < Y0 + TILE_SIZE);
      border_hit = tile_hit && ((h - X0 < BORDER_W) || (h - X0 >= TILE_SIZE - BORDER_W) ||
                                (v - Y0 < BORDER_W) || (v - Y0 >= TILE_SIZE - BORDER_W));
      glyph_hit  = tile_hit && (dx >= 0) && (dx < txt_w) && (dy >= 0) && (dy < FONT_H);
      slot       = dx / FONT_W;
      digit_idx  = int'(com_ndig) - 1 - slot;
      code       = 4'hF;
      if (glyph_hit) begin
         case (digit_idx)
            0:       code = com_bcd[3:0];
            1:       code = com_bcd[7:4];
            2:       code = com_bcd[11:8];
            3:       code = com_bcd[15:12];
            default: code = 4'hF;
         endcase
      end
   end

   logic              tile_q, glyph_q, border_q;
   logic [CW-1:0]     col_q;
   logic [3:0]        code_q;
   logic [11:0]       row_q;
   logic [FONT_W-1:0] font_row;
   logic              pix;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tile_q   <= 1'b0;
         glyph_q  <= 1'b0;
         border_q <= 1'b0;
         col_q    <= '0;
         code_q   <= 4'hF;
         row_q    <= '0;
      end else begin
         tile_q   <= tile_hit;
         glyph_q  <= glyph_hit;
         border_q <= border_hit;
         col_q    <= CW'(dx % FONT_W);
         code_q   <= code;
         row_q    <= 12'(dy);
      end
   end

   font_rom #(.FONT_W(FONT_W), .FONT_H(FONT_H)) u_font (
      .code       (code_q),
      .row        (row_q),
      .output_row (font_row)
   );

   assign pix = glyph_q && |(font_row & (COL0_MASK >> col_q));

   function automatic logic [11:0] bg_color(input logic [3:0] s);
      case (s)
         4'd0:    return 12'h000;
         4'd1:    return 12'hEED;
         4'd2:    return 12'hEEC;
         4'd3:    return 12'hFB7;
         4'd4:    return 12'hF96;
         4'd5:    return 12'hF75;
         4'd6:    return 12'hF53;
         4'd7:    return 12'hED7;
         4'd8:    return 12'hEC6;
         4'd9:    return 12'hEC5;
         4'd10:   return 12'hEC3;
         4'd11:   return 12'hEC2;
         default: return 12'h333;
      endcase
   endfunction

   function automatic logic [11:0] fg_color(input logic [3:0] s);
      case (s)
         4'd0:       return 12'h000;
         4'd1, 4'd2: return 12'h766;
         default:    return 12'hFFF;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_data <= 12'h000;
         in_tile  <= 1'b0;
      end else if (!tile_q) begin
         vga_data <= 12'h000;
         in_tile  <= 1'b0;
      end else begin
         in_tile <= 1'b1;
         if (border_q && anim_cnt != 8'd0) vga_data <= 12'hFFF;
         else if (pix)                     vga_data <= fg_color(com_state);
         else                              vga_data <= bg_color(com_state);
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_tile_render_engine.sv
`default_nettype none
// Scoreboard bench for tile_render_engine placed at (100,40) with default geometry.

module tb_tile_render_engine;
   localparam int X0 = 100;
   localparam int Y0 = 40;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_start = 1'b0;
   logic [3:0]  state = 4'd0;
   logic [11:0] h_cnt = 12'd0;
   logic [11:0] v_cnt = 12'd0;
   logic [11:0] vga_data;
   logic        in_tile;
   logic        busy;

   tile_render_engine #(.X0(X0), .Y0(Y0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .state       (state),
      .h_cnt       (h_cnt),
      .v_cnt       (v_cnt),
      .frame_start (frame_start),
      .vga_data    (vga_data),
      .in_tile     (in_tile),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] data;
      logic        in_t;
      int          id;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_vec = 0;
   int   n_fail = 0;
   int   vec_id = 0;
   logic probe = 1'b0, p1 = 1'b0, p2 = 1'b0;

   // Probe marker travels two clocks, matching the pixel latency.
   always @(posedge clk) begin
      p1 <= probe;
      p2 <= p1;
   end

   always @(negedge clk) begin
      if (p2) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pixel: vga_data=%h in_tile=%b, expected none queued", vga_data, in_tile);
         end else begin
            e = sb.pop_front();
            if (vga_data !== e.data || in_tile !== e.in_t) begin
               n_fail++;
               $display("FAIL pix%0d: vga_data=%h in_tile=%b, expected vga_data=%h in_tile=%b",
                        e.id, vga_data, in_tile, e.data, e.in_t);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pix(input int h, input int v, input logic [11:0] d, input logic it);
      h_cnt = 12'(h);
      v_cnt = 12'(v);
      probe = 1'b1;
      sb.push_back('{data: d, in_t: it, id: vec_id});
      vec_id++;
      tick(1);
      probe = 1'b0;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      tick(2);
   endtask

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tick(3);
      chk("rst_vga", vga_data, 12'h000);
      chk("rst_in_tile", {11'd0, in_tile}, 12'd0);
      chk("rst_busy", {11'd0, busy}, 12'd0);

      // Reset in the middle of a conversion, then no frame_start
      rst_n = 1'b1;
      tick(1);
      state = 4'd11;
      tick(6);
      chk("busy_in_shift", {11'd0, busy}, 12'd1);
      rst_n = 1'b0;
      #1;
      chk("busy_abort", {11'd0, busy}, 12'd0);
      tick(2);
      rst_n = 1'b1;
      tick(25);
      chk("busy_idle", {11'd0, busy}, 12'd0);
      pix(150, 100, 12'h000, 1'b1);
      pix(180, 113, 12'h000, 1'b1);
      tick(3);

      // 2048: gx=142, gy=98
      frame();
      pix(147, 100, 12'hFFF, 1'b1);
      pix(142, 98, 12'hEC2, 1'b1);
      pix(179, 100, 12'hEC2, 1'b1);
      pix(176, 103, 12'hFFF, 1'b1);
      pix(198, 113, 12'hFFF, 1'b1);
      pix(166, 113, 12'hEC2, 1'b1);
      pix(110, 100, 12'hEC2, 1'b1);
      pix(102, 60, 12'hFFF, 1'b1);
      pix(247, 187, 12'hFFF, 1'b1);
      pix(99, 50, 12'h000, 1'b0);
      pix(248, 50, 12'h000, 1'b0);
      pix(150, 39, 12'h000, 1'b0);
      pix(150, 188, 12'h000, 1'b0);
      tick(3);

      // 3 -> 4: "16" at gx=158 with pop border
      state = 4'd3;
      tick(25);
      frame();
      state = 4'd4;
      tick(25);
      frame();
      pix(170, 103, 12'hFFF, 1'b1);
      pix(160, 103, 12'hF96, 1'b1);
      pix(179, 100, 12'hFFF, 1'b1);
      pix(157, 103, 12'hF96, 1'b1);
      pix(102, 60, 12'hFFF, 1'b1);
      tick(3);
      repeat (7) frame();
      pix(102, 60, 12'hFFF, 1'b1);
      tick(3);
      frame();
      pix(102, 60, 12'hF96, 1'b1);
      tick(3);

      // 5 -> 9 during SHIFT: "512" at gx=150
      state = 4'd5;
      tick(4);
      chk("busy_restart", {11'd0, busy}, 12'd1);
      state = 4'd9;
      tick(25);
      frame();
      pix(152, 103, 12'hFFF, 1'b1);
      pix(162, 103, 12'hEC5, 1'b1);
      pix(178, 103, 12'hFFF, 1'b1);
      pix(171, 100, 12'hEC5, 1'b1);
      pix(184, 118, 12'hFFF, 1'b1);
      tick(3);

      // frame_start while busy defers the commit
      state = 4'd10;
      tick(3);
      chk("busy_defer", {11'd0, busy}, 12'd1);
      frame();
      pix(152, 103, 12'hFFF, 1'b1);
      pix(162, 103, 12'hEC5, 1'b1);
      tick(25);
      pix(152, 103, 12'hFFF, 1'b1);
      tick(3);
      frame();
      pix(154, 103, 12'hFFF, 1'b1);
      pix(152, 103, 12'hEC3, 1'b1);
      tick(3);

      // Out-of-table background colour
      state = 4'd12;
      tick(25);
      frame();
      pix(110, 100, 12'h333, 1'b1);
      tick(3);

      // Empty tile after the pop has expired
      repeat (9) frame();
      state = 4'd0;
      tick(25);
      frame();
      pix(174, 113, 12'h000, 1'b1);
      pix(102, 60, 12'h000, 1'b1);
      pix(150, 100, 12'h000, 1'b1);
      tick(4);

      if (sb.size() != 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expected pixels never observed, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
